multicycle_controller: RTL

- Sequencing FSM that drives the multicycle variant of the RV32I core datapath: one shared memory port, one ALU, registers between steps.
- Decodes Op, funct3 and funct7 each instruction and produces per-state datapath enables and multiplexer selects.
- Handles the shared-memory ready handshake and counts retired instructions.
- Sits between the instruction register and the datapath. It is the multicycle counterpart of the single-cycle control unit.

---
 rtl/multicycle_controller_pkg.sv | 65 ++++++
 rtl/multicycle_controller_alu_decoder.sv | 37 +++
 rtl/multicycle_controller.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multicycle RV32I controller: FSM state
// encoding, opcode constants, ALUOp / ALUControl codes, datapath mux
// select encodings and the immediate-format decode helper.
package multicycle_controller_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_HALT     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Immediate format follows the opcode alone; unknown opcodes fall to I.
    function automatic logic [1:0] imm_src(input logic [6:0] op);
        case (op)
            OP_STORE:  imm_src = IMM_S;
            OP_BRANCH: imm_src = IMM_B;
            OP_JAL:    imm_src = IMM_J;
            default:   imm_src = IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU decoder: maps ALUOp plus funct3/funct7[5] to the ALU operation.
// Ports:
//   aluop_i      ALUOp from the FSM (00 add, 01 sub, 10 funct decode)
//   funct3_i     instruction funct3
//   funct7b5_i   instruction funct7[5]
//   opb5_i       opcode bit 5 (1 for R-type, 0 for I-type ALU ops)
//   alucontrol_o ALU operation code
module multicycle_controller_alu_decoder
    import multicycle_controller_pkg::*;
(
    input  logic [1:0] aluop_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    input  logic       opb5_i,
    output logic [2:0] alucontrol_o
);

    always_comb begin
        alucontrol_o = ALU_ADD;
        case (aluop_i)
            ALUOP_SUB: alucontrol_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3_i)
                    // funct7[5] only selects sub for register-register ops;
                    // addi immediates may have that bit set.
                    3'b000:  alucontrol_o = (funct7b5_i & opb5_i) ? ALU_SUB : ALU_ADD;
                    3'b111:  alucontrol_o = ALU_AND;
                    3'b110:  alucontrol_o = ALU_OR;
                    3'b010:  alucontrol_o = ALU_SLT;
                    default: alucontrol_o = ALU_ADD;
                endcase
            end
            default: alucontrol_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I sequencing controller. Moore FSM producing per-state
// datapath enables and mux selects, a shared-memory ready handshake and a
// retired-instruction counter.
// Build option: ILLEGAL_TRAP_EN -- when defined, unsupported opcodes halt
// the controller and raise a sticky Illegal flag; otherwise they are NOPs.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   Op, funct3, funct7  instruction fields from the instruction register
//   Zero                ALU zero flag (branch decision)
//   MemReady            memory completed the current access
//   MemReq..ALUControl  datapath controls
//   InstrRetired        retired-instruction count (wraps)
//   Illegal             sticky illegal-opcode flag
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       Op,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic             Zero,
    input  logic             MemReady,
    output logic             MemReq,
    output logic             AdrSrc,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             RegWrite,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ImmSrc,
    output logic [2:0]       ALUControl,
    output logic [CNT_W-1:0] InstrRetired,
    output logic             Illegal
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] retired_q;
    logic             retire;

    logic       mem_req, adr_src, mem_write, ir_write, pc_write, reg_write;
    logic [1:0] src_a, src_b, res_src, aluop;
    logic [2:0] alu_ctrl;

    // Only funct7[5] participates in decode.
    logic unused_funct7;
    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    always_comb begin
        state_d   = state_q;
        mem_req   = 1'b0;
        adr_src   = 1'b0;
        mem_write = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        reg_write = 1'b0;
        src_a     = SRCA_PC;
        src_b     = SRCB_RS2;
        res_src   = RES_ALUOUT;
        aluop     = ALUOP_ADD;
        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                src_b   = SRCB_FOUR;
                res_src = RES_ALURES;
                // FETCH is left on the ready cycle, so a ready held high
                // still yields exactly one IR load per visit.
                if (MemReady) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                src_a = SRCA_OLDPC;
                src_b = SRCB_IMM;
                case (Op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BEQ;
                    OP_JAL:            state_d = S_JAL;
`ifdef ILLEGAL_TRAP_EN
                    default:           state_d = S_HALT;
`else
                    default:           state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                src_a   = SRCA_RS1;
                src_b   = SRCB_IMM;
                state_d = (Op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (MemReady) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                res_src   = RES_DATA;
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req   = 1'b1;
                adr_src   = 1'b1;
                mem_write = 1'b1;
                if (MemReady) state_d = S_FETCH;
            end
            S_EXECR: begin
                src_a   = SRCA_RS1;
                src_b   = SRCB_RS2;
                aluop   = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                src_a   = SRCA_RS1;
                src_b   = SRCB_IMM;
                aluop   = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_BEQ: begin
                src_a    = SRCA_RS1;
                src_b    = SRCB_RS2;
                aluop    = ALUOP_SUB;
                pc_write = Zero;
                state_d  = S_FETCH;
            end
            S_JAL: begin
                src_a    = SRCA_OLDPC;
                src_b    = SRCB_FOUR;
                pc_write = 1'b1;
                state_d  = S_ALUWB;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    // Illegal-opcode NOPs re-enter FETCH from DECODE and are not counted.
    assign retire = (state_d == S_FETCH) &&
                    (state_q inside {S_MEMWB, S_MEMWRITE, S_ALUWB, S_BEQ});

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) retired_q <= retired_q + CNT_ONE;
        end
    end

    multicycle_controller_alu_decoder u_alu_decoder (
        .aluop_i      (aluop),
        .funct3_i     (funct3),
        .funct7b5_i   (funct7[5]),
        .opb5_i       (Op[5]),
        .alucontrol_o (alu_ctrl)
    );

    // Outputs are forced low for the whole reset window, including the
    // first reset cycle before the state register has been loaded.
    assign MemReq       = ~rst & mem_req;
    assign AdrSrc       = ~rst & adr_src;
    assign MemWrite     = ~rst & mem_write;
    assign IRWrite      = ~rst & ir_write;
    assign PCWrite      = ~rst & pc_write;
    assign RegWrite     = ~rst & reg_write;
    assign ALUSrcA      = rst ? 2'b00 : src_a;
    assign ALUSrcB      = rst ? 2'b00 : src_b;
    assign ResultSrc    = rst ? 2'b00 : res_src;
    assign ImmSrc       = rst ? 2'b00 : imm_src(Op);
    assign ALUControl   = rst ? 3'b000 : alu_ctrl;
    assign InstrRetired = rst ? '0 : retired_q;

`ifdef ILLEGAL_TRAP_EN
    // HALT is only left through reset, so being in HALT is the sticky flag.
    assign Illegal = ~rst & (state_q == S_HALT);
`else
    assign Illegal = 1'b0;
`endif

endmodule
